// File: rtl/console_pkg.sv
// Shared console definitions: byte width, line terminator, arbiter state type
// and a saturating counter helper.
package console_pkg;

    localparam int unsigned CONSOLE_BYTE_W = 8;
    localparam logic [CONSOLE_BYTE_W-1:0] CONSOLE_LINE_END = 8'h0A;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    // 8-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == '1) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/console_put_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first asserted request
// searching last+1, last+2, ... modulo NUM_REQ. Also used by the drain scheduler.
module rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last,
    output logic [GRANT_W-1:0] pick_id,
    output logic               pick_valid
);

    logic [31:0]        idx_full;
    logic [GRANT_W-1:0] idx;

    // Walk the ring starting just after the previous winner; first hit wins.
    always_comb begin
        pick_id    = '0;
        pick_valid = 1'b0;
        idx_full   = '0;
        idx        = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx_full = (32'(last) + off) % NUM_REQ;
            idx      = GRANT_W'(idx_full);
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick_id    = idx;
            end
        end
    end

endmodule

// File: rtl/console_put_arbiter.sv
// Line-locked round-robin arbiter sharing the CPU console put method among
// NUM_REQ byte sources. A grant is held until LINE_END, MAX_BURST bytes,
// IDLE_TIMEOUT quiet cycles, or loss of cpu_reset_completed.
module console_put_arbiter
    import console_pkg::*;
#(
    parameter int unsigned                NUM_REQ      = 2,
    parameter int unsigned                MAX_BURST    = 64,
    parameter int unsigned                IDLE_TIMEOUT = 16,
    parameter logic [CONSOLE_BYTE_W-1:0]  LINE_END     = CONSOLE_LINE_END,
    parameter int unsigned                GRANT_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cpu_reset_completed,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*CONSOLE_BYTE_W-1:0] req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic                              RDY_put_from_console_put,
    output logic [CONSOLE_BYTE_W-1:0]         put_from_console_put,
    output logic                              EN_put_from_console_put,
    output logic                              grant_valid,
    output logic [GRANT_W-1:0]                grant_id,
    output logic [15:0]                       bytes_forwarded
);

    arb_state_t                 state_q, state_d;
    logic [GRANT_W-1:0]         grant_id_q, grant_id_d;
    logic [GRANT_W-1:0]         last_grant_q, last_grant_d;
    logic [7:0]                 burst_cnt_q, burst_cnt_d;
    logic [7:0]                 idle_cnt_q, idle_cnt_d;
    logic [15:0]                bytes_q, bytes_d;

    logic                       go;
    logic                       xfer;
    logic                       release_now;
    logic [CONSOLE_BYTE_W-1:0]  sel_data;
    logic                       sel_valid;
    logic [GRANT_W-1:0]         pick_id;
    logic                       pick_valid;

    assign go = cpu_reset_completed & RDY_put_from_console_put;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_pick (
        .req        (req_valid),
        .last       (last_grant_q),
        .pick_id    (pick_id),
        .pick_valid (pick_valid)
    );

    // Select the current holder's byte and valid flag.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == GRANT_W'(i)) begin
                sel_data  = req_data[i*CONSOLE_BYTE_W +: CONSOLE_BYTE_W];
                sel_valid = req_valid[i];
            end
        end
    end

    // Next-state, counter updates and port outputs for the grant FSM.
    always_comb begin
        state_d                 = state_q;
        grant_id_d              = grant_id_q;
        last_grant_d            = last_grant_q;
        burst_cnt_d             = burst_cnt_q;
        idle_cnt_d              = idle_cnt_q;
        bytes_d                 = bytes_q;
        xfer                    = 1'b0;
        release_now             = 1'b0;
        EN_put_from_console_put = 1'b0;
        put_from_console_put    = '0;
        req_ready               = '0;

        unique case (state_q)
            ARB_IDLE: begin
                if (cpu_reset_completed && pick_valid) begin
                    state_d    = ARB_LOCKED;
                    grant_id_d = pick_id;
                end
            end

            ARB_LOCKED: begin
                put_from_console_put    = sel_data;
                xfer                    = sel_valid & go;
                EN_put_from_console_put = xfer;
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = go && (grant_id_q == GRANT_W'(i));
                end

                if (!cpu_reset_completed) begin
                    release_now = 1'b1;
                end else if (xfer) begin
                    burst_cnt_d = sat_inc8(burst_cnt_q);
                    idle_cnt_d  = '0;
                    bytes_d     = bytes_q + 16'd1;
                    if (sel_data == LINE_END || burst_cnt_d >= 8'(MAX_BURST)) begin
                        release_now = 1'b1;
                    end
                end else if (!sel_valid) begin
                    // Stalls from RDY with data pending are not idleness.
                    idle_cnt_d = sat_inc8(idle_cnt_q);
                    if (idle_cnt_d >= 8'(IDLE_TIMEOUT)) begin
                        release_now = 1'b1;
                    end
                end

                if (release_now) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = grant_id_q;
                    burst_cnt_d  = '0;
                    idle_cnt_d   = '0;
                end
            end

            default: state_d = ARB_IDLE;
        endcase
    end

    // State and counter registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            grant_id_q   <= '0;
            last_grant_q <= GRANT_W'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
            idle_cnt_q   <= '0;
            bytes_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            bytes_q      <= bytes_d;
        end
    end

    assign grant_valid     = (state_q == ARB_LOCKED);
    assign grant_id        = grant_id_q;
    assign bytes_forwarded = bytes_q;

endmodule
